serial_logic_unit: RTL

Parametrised, bit-serial generalisation of the team's two-input logic function blocks. A 4-bit truth-table code selects any two-input Boolean function, including the existing `~a & b`. The block applies that function bitwise to two WIDTH-bit operands, one bit per clock, under a start/busy/done handshake. It sits behind the course test benches and register-file exercises as the shared sequential logic unit, replacing the per-function combinational modules.

---
 rtl/serial_logic_unit_if.sv | 26 ++
 rtl/serial_logic_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/serial_logic_unit_if.sv
// Handshake and operand/result bundle for the bit-serial logic unit.
// The master drives requests; the slave returns status and the result.
interface serial_logic_unit_if #(
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(WIDTH + 1);

    logic             start;
    logic [3:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic [CW-1:0]    ones;

    modport master (
        output start, func, a, b,
        input  busy, done, s, ones
    );

    modport slave (
        input  start, func, a, b,
        output busy, done, s, ones
    );
endinterface

// File: rtl/serial_logic_unit.sv
// Bit-serial two-input logic unit: applies a 4-bit truth table to two
// WIDTH-bit operands one bit per clock, with a population count of the result.
module serial_logic_unit #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    serial_logic_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic             w_last;
    logic             w_r;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_func;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_acc;
    logic [WIDTH-1:0] r_s;
    logic [CW-1:0]    r_ones;
    logic             r_done;
    logic [WIDTH:0]   w_cat;
    logic [WIDTH-1:0] w_res_nx;
    logic [CW-1:0]    w_acc_nx;

    assign w_r      = r_func[{r_a[0], r_b[0]}];
    // New bit enters at the MSB; after WIDTH shifts bit i lines up with operand bit i.
    assign w_cat    = {w_r, r_res};
    assign w_res_nx = w_cat[WIDTH:1];
    assign w_acc_nx = r_acc + CW'(w_r);

    always_comb begin
        w_state_nx = r_state;
        w_last     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_state_nx = IDLE;
                    w_last     = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_func  <= '0;
            r_res   <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_ones  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_done  <= w_last;
            if (r_state == IDLE) begin
                if (bus.start) begin
                    r_a    <= bus.a;
                    r_b    <= bus.b;
                    r_func <= bus.func;
                    r_res  <= '0;
                    r_acc  <= '0;
                    r_cnt  <= '0;
                end
            end else begin
                r_a   <= r_a >> 1;
                r_b   <= r_b >> 1;
                r_res <= w_res_nx;
                r_acc <= w_acc_nx;
                r_cnt <= r_cnt + 1'b1;
                if (w_last) begin
                    r_s    <= w_res_nx;
                    r_ones <= w_acc_nx;
                end
            end
        end
    end

    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
    assign bus.s    = r_s;
    assign bus.ones = r_ones;
endmodule
